load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have the port `clk  in  1`: rising-edge clock for all state.
REQ-002 The block SHALL have the port `rst_n  in  1`: reset, asynchronous, active-low.
REQ-003 The block SHALL have the port `req_valid  in  1`: CPU access request.
REQ-004 The block SHALL have the port `req_ready  out  1`: block can accept a request.
REQ-005 The block SHALL have the port `req_we  in  1`: 1 = store, 0 = load.
REQ-006 The block SHALL have the port `req_size  in  2`: 00 byte, 01 half, 10 word; 11 is reserved and treated as word.
REQ-007 The block SHALL have the port `req_unsigned  in  1`: loads zero-extend when 1 and sign-extend when 0.
REQ-008 The block SHALL have the port `req_addr  in  32`: byte address.
REQ-009 The block SHALL have the port `req_wdata  in  32`: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 The block SHALL have the port `resp_valid  out  1`: one-cycle completion pulse.
REQ-011 The block SHALL have the port `resp_rdata  out  32`: extended load data; 0 for stores.
REQ-012 The block SHALL have the port `resp_err  out  1`: misaligned access flag, valid with resp_valid.
REQ-013 The block SHALL have the port `mem_rd_en  out  1`: data memory read enable.
REQ-014 The block SHALL have the port `mem_wr_en  out  1`: data memory write enable.
REQ-015 The block SHALL have the port `mem_addr  out  32`: word index, equal to req_addr[31:2] zero-extended.
REQ-016 The block SHALL have the port `mem_wr_data  out  32`: full word to write.
REQ-017 The block SHALL have the port `mem_rdata  in  32`: combinational read data, valid in the same cycle as mem_rd_en.

Function
REQ-018 The block SHALL implement the FSM states IDLE, READ, WRITE, RESP; req_ready SHALL equal (state==IDLE).
REQ-019 In IDLE, on req_valid=1 at a rising edge, the block SHALL latch all req_* fields and then transition:
- load -> READ;
- word store -> WRITE;
- byte/half store -> READ (read-modify-write).
REQ-020 In READ, the block SHALL drive mem_rd_en=1 and mem_addr from the registered address, and capture mem_rdata at the next rising edge.
- Load: READ -> RESP.
- Sub-word store: READ -> WRITE.
REQ-021 In WRITE, the block SHALL drive mem_wr_en=1 for exactly one cycle, holding mem_addr and mem_wr_data stable for the whole cycle, then go to RESP.
REQ-022 In RESP, the block SHALL drive resp_valid=1 for exactly one cycle and then return to IDLE; the response SHALL have no backpressure.
REQ-023 mem_rd_en and mem_wr_en SHALL never be asserted together, and both SHALL be 0 in IDLE and RESP.
REQ-024 Latency from the accept edge to resp_valid SHALL be 2 cycles for a load or word store and 3 cycles for a byte/half store.
REQ-025 Load extraction SHALL use the following lanes, then extend to 32 bits per req_unsigned:
- byte lane = addr[1:0], bits [8*lane+7 : 8*lane];
- half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]];
- word = all 32 bits.
REQ-026 For a sub-word store, the block SHALL replace only the addressed byte/half lane of the captured word with req_wdata's low bits and leave the other lanes unchanged.
REQ-027 Requests presented while req_ready=0 SHALL be ignored, and the requester SHALL hold req_valid until accepted.
REQ-028 An address with upper bits set SHALL pass through unchanged to mem_addr; the block performs no range check.

Reset
REQ-029 While rst_n=0, the block SHALL immediately force the following, independent of clk:
- state = IDLE;
- mem_rd_en = mem_wr_en = 0;
- resp_valid = resp_err = 0;
- mem_addr = mem_wr_data = resp_rdata = 0.
REQ-030 A reset asserted mid-operation SHALL abort the access: no write SHALL be issued and no response SHALL be produced.
REQ-031 After reset deasserts, req_ready SHALL be 1.

Configuration
REQ-032 The block SHALL use the macro MISALIGN_CHECK_EN to select misalignment handling.
- Defined: half with addr[0]=1, or word with addr[1:0]!=0, SHALL go IDLE -> RESP with no memory access, resp_err=1 and resp_rdata=0.
- Undefined: resp_err SHALL be tied 0; low address bits below natural alignment SHALL be ignored (half uses addr[1] only, word ignores addr[1:0]).

Verification
REQ-033 Bench scenario, word store then load:
- store addr 0x10, data 0xDEADBEEF -> mem_wr_en for one cycle with mem_addr=4 and mem_wr_data=0xDEADBEEF; resp_valid 2 cycles after accept;
- load word 0x10 -> resp_rdata=0xDEADBEEF.
REQ-034 Bench scenario, byte RMW: memory word 4 = 0x11223344; store byte addr 0x12, data 0xAA -> write 0x11AA3344, resp_valid 3 cycles after accept.
REQ-035 Bench scenario, extension: word 0x80FF7F01 at 0x20.
- Load byte 0x21 signed -> 0x0000007F.
- Load byte 0x23 signed -> 0xFFFFFF80.
- Load half 0x22 unsigned -> 0x000080FF.
REQ-036 Bench scenario, misaligned word load at 0x13:
- MISALIGN_CHECK_EN defined -> resp_err=1, resp_rdata=0, no mem_rd_en;
- undefined -> reads word 4, resp_err=0.
REQ-037 Bench scenario, reset during WRITE state: rst_n low -> mem_wr_en drops the same cycle, memory is unchanged, no resp_valid, and req_ready=1 after release.
REQ-038 Bench scenario, back-to-back: req_valid held high for two loads -> second accepted only in the cycle after the first resp_valid, and mem_rd_en/mem_wr_en are never both high.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding access FSM with sub-word extract and read-modify-write.
// Optional misalignment trapping is enabled by defining MISALIGN_CHECK_EN.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] word_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        mis;
    logic        accept;

    function automatic logic [31:0] extract(
        input logic [31:0] w,
        input logic [1:0]  a,
        input logic [1:0]  sz,
        input logic        u
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   extract = {{24{~u & b[7]}}, b};
            2'b01:   extract = {{16{~u & h[15]}}, h};
            default: extract = w;
        endcase
    endfunction

    // Only the addressed lane takes store data; the rest keep the memory word.
    function automatic logic [31:0] merge(
        input logic [31:0] w,
        input logic [1:0]  a,
        input logic [1:0]  sz,
        input logic [31:0] d
    );
        logic [31:0] r;
        r = w;
        case (sz)
            2'b00:   r[{a, 3'b000} +: 8] = d[7:0];
            2'b01:   r[{a[1], 4'b0000} +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

`ifdef MISALIGN_CHECK_EN
    assign mis = ((req_size == 2'b01) & req_addr[0]) |
                 (req_size[1] & (|req_addr[1:0]));
`else
    assign mis = 1'b0;
`endif

    assign accept = req_valid & (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (mis)
                        state_nxt = RESP;
                    else if (req_we && req_size[1])
                        state_nxt = WRITE;
                    else
                        state_nxt = READ;
                end
            end
            READ: begin
                mem_rd_en = 1'b1;
                state_nxt = we_q ? WRITE : RESP;
            end
            WRITE: begin
                mem_wr_en = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // word_q holds the store data, then the merged word for sub-word stores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            addr_q  <= req_addr;
            word_q  <= req_wdata;
            rdata_q <= '0;
            err_q   <= mis;
        end else if (state == READ) begin
            if (we_q)
                word_q <= merge(mem_rdata, addr_q[1:0], size_q, word_q);
            else
                rdata_q <= extract(mem_rdata, addr_q[1:0], size_q, uns_q);
        end
    end

    assign mem_addr    = {2'b00, addr_q[31:2]};
    assign mem_wr_data = word_q;
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset/back-to-back sequences, random ops.
// A small word-array memory and an arithmetic reference model live in the bench.
module tb_load_store_unit;

`ifdef MISALIGN_CHECK_EN
    localparam bit MC = 1'b1;
`else
    localparam bit MC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rdata;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[5:0]];

    always @(posedge clk)
        if (mem_wr_en) mem[mem_addr[5:0]] <= mem_wr_data;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    // Expected behaviour from the access rules; updates ref_mem for stores.
    task automatic ref_op(
        input  logic        we, input logic [1:0] sz, input logic u,
        input  logic [31:0] a, input logic [31:0] d,
        output logic [31:0] rd, output logic e, output int lat,
        output int rdc, output int wrc, output logic [31:0] wd
    );
        logic [31:0] w, v, mask;
        int lane;
        w = ref_mem[a[7:2]];
        rd = 0; e = 0; wd = 0;
        if (MC && ((sz == 1 && a[0]) || (sz >= 2 && a[1:0] != 0))) begin
            e = 1; lat = 1; rdc = 0; wrc = 0;
        end else if (!we) begin
            lat = 2; rdc = 1; wrc = 0;
            if (sz == 0) begin
                lane = int'(a[1:0]);
                v = (w >> (8 * lane)) & 32'hFF;
                if (!u && v >= 128) v = v | 32'hFFFFFF00;
            end else if (sz == 1) begin
                lane = int'(a[1]);
                v = (w >> (16 * lane)) & 32'hFFFF;
                if (!u && v >= 32768) v = v | 32'hFFFF0000;
            end else begin
                v = w;
            end
            rd = v;
        end else begin
            wrc = 1;
            if (sz >= 2) begin
                lat = 2; rdc = 0; wd = d;
            end else begin
                lat = 3; rdc = 1;
                if (sz == 0) begin
                    lane = int'(a[1:0]);
                    mask = 32'hFF << (8 * lane);
                    wd = (w & ~mask) | ((d & 32'hFF) << (8 * lane));
                end else begin
                    lane = int'(a[1]);
                    mask = 32'hFFFF << (16 * lane);
                    wd = (w & ~mask) | ((d & 32'hFFFF) << (16 * lane));
                end
            end
            ref_mem[a[7:2]] = wd;
        end
    endtask

    // Issues one request and observes it through to completion.
    task automatic run_txn(
        input  logic        we, input logic [1:0] sz, input logic u,
        input  logic [31:0] a, input logic [31:0] d,
        output logic [31:0] rd, output logic e, output int lat,
        output int rdc, output int wrc, output int both,
        output logic [31:0] wa, output logic [31:0] wd,
        output logic again
    );
        int n = 0;
        rd = 0; e = 0; rdc = 0; wrc = 0; both = 0;
        wa = 0; wd = 0; again = 0;
        @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = d; req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (lat <= 8) begin
            if (mem_rd_en && mem_wr_en) both++;
            if (mem_rd_en) rdc++;
            if (mem_wr_en) begin
                wrc++; wa = mem_addr; wd = mem_wr_data;
            end
            if (resp_valid) begin
                rd = resp_rdata; e = resp_err;
                break;
            end
            @(negedge clk);
            lat++;
        end
        if (lat > 8) lat = 99;
        @(negedge clk);
        again = resp_valid;
    endtask

    task automatic do_check(
        input string tag,
        input logic we, input logic [1:0] sz, input logic u,
        input logic [31:0] a, input logic [31:0] d,
        input logic [31:0] exp_rd, input logic exp_e, input int exp_lat
    );
        logic [31:0] rrd, rwd, grd, gwa, gwd;
        logic re, ge, again;
        int rlat, rrdc, rwrc, glat, grdc, gwrc, gboth;
        ref_op(we, sz, u, a, d, rrd, re, rlat, rrdc, rwrc, rwd);
        run_txn(we, sz, u, a, d, grd, ge, glat, grdc, gwrc, gboth,
                gwa, gwd, again);
        chk({tag, " rdata"}, grd, exp_rd);
        chk({tag, " err"}, 32'(ge), 32'(exp_e));
        chk({tag, " latency"}, 32'(glat), 32'(exp_lat));
        chk({tag, " rd_cycles"}, 32'(grdc), 32'(rrdc));
        chk({tag, " wr_cycles"}, 32'(gwrc), 32'(rwrc));
        chk({tag, " rd_wr_overlap"}, 32'(gboth), 32'd0);
        chk({tag, " resp_one_cycle"}, 32'(again), 32'd0);
        if (rwrc != 0) begin
            chk({tag, " wr_addr"}, gwa, {2'b00, a[31:2]});
            chk({tag, " wr_data"}, gwd, rwd);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_e;
        int          exp_lat;
    } vec_t;

    vec_t vt[$];

    initial begin
        logic [31:0] v, rrd, rwd, rdA, rdB, pre;
        logic re, rwe, ru;
        logic [1:0] rsz;
        int rlat, rrdc, rwrc, n1, n2, r1, r2, both;

        rst_n = 1'b1; req_valid = 0; req_we = 0; req_size = 0;
        req_unsigned = 0; req_addr = 0; req_wdata = 0;
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            mem[i] = v;
            ref_mem[i] = v;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_err", 32'(resp_err), 32'd0);
        chk("reset rd_en", 32'(mem_rd_en), 32'd0);
        chk("reset wr_en", 32'(mem_wr_en), 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset wr_data", mem_wr_data, 32'd0);
        chk("reset rdata", resp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        vt.push_back('{1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2});
        vt.push_back('{0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2});
        vt.push_back('{1, 2'd2, 0, 32'h10, 32'h11223344, 32'h0, 0, 2});
        vt.push_back('{1, 2'd0, 0, 32'h12, 32'hAA, 32'h0, 0, 3});
        vt.push_back('{0, 2'd2, 0, 32'h10, 32'h0, 32'h11AA3344, 0, 2});
        vt.push_back('{1, 2'd2, 0, 32'h20, 32'h80FF7F01, 32'h0, 0, 2});
        vt.push_back('{0, 2'd0, 0, 32'h21, 32'h0, 32'h0000007F, 0, 2});
        vt.push_back('{0, 2'd0, 0, 32'h23, 32'h0, 32'hFFFFFF80, 0, 2});
        vt.push_back('{0, 2'd1, 1, 32'h22, 32'h0, 32'h000080FF, 0, 2});
        vt.push_back('{0, 2'd1, 0, 32'h22, 32'h0, 32'hFFFF80FF, 0, 2});
        if (MC)
            vt.push_back('{0, 2'd2, 0, 32'h13, 32'h0, 32'h0, 1, 1});
        else
            vt.push_back('{0, 2'd2, 0, 32'h13, 32'h0, 32'h11AA3344, 0, 2});
        vt.push_back('{1, 2'd1, 0, 32'h22, 32'hFFFF1234, 32'h0, 0, 3});
        vt.push_back('{0, 2'd2, 0, 32'h20, 32'h0, 32'h12347F01, 0, 2});
        vt.push_back('{0, 2'd3, 0, 32'hF0000020, 32'h0, 32'h12347F01, 0, 2});
        foreach (vt[i])
            do_check($sformatf("vec%0d", i), vt[i].we, vt[i].sz, vt[i].u,
                     vt[i].a, vt[i].d, vt[i].exp_rd, vt[i].exp_e,
                     vt[i].exp_lat);

        // Reset while the write strobe is up must abort the store.
        pre = mem[12];
        @(negedge clk);
        req_we = 1; req_size = 2'd2; req_addr = 32'h30;
        req_wdata = ~pre; req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        chk("rst_mid wr_en_before", 32'(mem_wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid wr_en_drop", 32'(mem_wr_en), 32'd0);
        chk("rst_mid resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid req_ready", 32'(req_ready), 32'd1);
        n1 = 0;
        for (int c = 0; c < 4; c++) begin
            if (resp_valid) n1++;
            @(negedge clk);
        end
        chk("rst_mid no_resp", 32'(n1), 32'd0);
        chk("rst_mid mem_kept", mem[12], pre);

        // Two loads with req_valid held high throughout.
        @(negedge clk);
        req_we = 0; req_size = 2'd2; req_unsigned = 0;
        req_addr = 32'h10; req_valid = 1;
        n1 = -1; n2 = -1; r1 = -1; r2 = -1; both = 0;
        rdA = 0; rdB = 0;
        for (int c = 0; c < 20; c++) begin
            if (mem_rd_en && mem_wr_en) both++;
            if (resp_valid) begin
                if (r1 < 0) begin r1 = c; rdA = resp_rdata; end
                else if (r2 < 0) begin r2 = c; rdB = resp_rdata; end
            end
            if (req_ready && req_valid) begin
                if (n1 < 0) n1 = c;
                else if (n2 < 0) n2 = c;
            end
            @(negedge clk);
            if (n1 >= 0 && n2 < 0) req_addr = 32'h20;
            if (n2 >= 0) req_valid = 0;
        end
        chk("b2b first_latency", 32'(r1 - n1), 32'd2);
        chk("b2b second_accept", 32'(n2), 32'(r1 + 1));
        chk("b2b second_latency", 32'(r2 - n2), 32'd2);
        chk("b2b rdata_a", rdA, ref_mem[4]);
        chk("b2b rdata_b", rdB, ref_mem[8]);
        chk("b2b overlap", 32'(both), 32'd0);

        for (int i = 0; i < 150; i++) begin
            rwe = 1'($urandom_range(0, 1));
            rsz = 2'($urandom_range(0, 3));
            ru = 1'($urandom_range(0, 1));
            v = {$urandom_range(0, 15) == 0 ? 24'($urandom) : 24'h0,
                 8'($urandom)};
            rwd = $urandom;
            begin
                logic [31:0] grd, gwa, gwd;
                logic ge, again;
                int glat, grdc, gwrc, gboth;
                ref_op(rwe, rsz, ru, v, rwd, rrd, re, rlat, rrdc, rwrc, rdB);
                run_txn(rwe, rsz, ru, v, rwd, grd, ge, glat, grdc, gwrc,
                        gboth, gwa, gwd, again);
                chk($sformatf("rnd%0d rdata", i), grd, rrd);
                chk($sformatf("rnd%0d err", i), 32'(ge), 32'(re));
                chk($sformatf("rnd%0d latency", i), 32'(glat), 32'(rlat));
                chk($sformatf("rnd%0d wr_cycles", i), 32'(gwrc), 32'(rwrc));
                chk($sformatf("rnd%0d overlap", i), 32'(gboth), 32'd0);
                if (rwrc != 0) begin
                    chk($sformatf("rnd%0d wr_addr", i), gwa, {2'b00, v[31:2]});
                    chk($sformatf("rnd%0d wr_data", i), gwd, rdB);
                end
            end
        end
        for (int i = 0; i < 64; i++)
            if (mem[i] !== ref_mem[i]) begin
                tests++;
                fails++;
                $display("FAIL final_mem[%0d]: got %h want %h",
                         i, mem[i], ref_mem[i]);
            end else begin
                tests++;
            end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
